// File: rtl/logic_response_checker.sv
// logic_response_checker: sweeps x through 0..15, checks y against ~yinv per vector and reports done/pass.
// Optional LRC_SIG_CHECK_EN adds a 16-bit MISR over y and folds signature==EXP_SIG into pass.
module logic_response_checker #(
   parameter int          NUM_OUT = 3,
   parameter int          SETTLE  = 1,
   parameter logic [15:0] SEED    = 16'hFFFF,
   parameter logic [15:0] EXP_SIG = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [3:0]         x,
   input  logic [NUM_OUT-1:0] y,
   input  logic [NUM_OUT-1:0] yinv,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [4:0]         err_cnt,
   output logic [15:0]        signature
);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
   localparam state_t     S_FIRST  = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
   localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);
   state_t state_q, state_d;
   logic [3:0] x_q, x_d, cnt_q, cnt_d;
   logic [4:0] err_q, err_d;
   logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic launch, sample, last, mis, sig_ok;
   assign launch = start && (state_q == S_IDLE || state_q == S_DONE);
   assign sample = state_q == S_SAMPLE;
   assign last   = sample && x_q == 4'hF;
   assign mis    = |(y ~^ yinv);
`ifdef LRC_SIG_CHECK_EN
   logic [15:0] sig_q, sig_d;
   always_comb begin
      sig_d = launch ? SEED
            : sample ? ({sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ 16'(y))
            : sig_q;
   end
   always_ff @(posedge clk) begin
      if (rst) sig_q <= SEED;
      else     sig_q <= sig_d;
   end
   assign sig_ok    = sig_d == EXP_SIG;
   assign signature = sig_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{SEED, EXP_SIG};
   assign sig_ok     = 1'b1;
   assign signature  = '0;
`endif
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_FIRST;
         S_SETTLE:       if (cnt_q == LAST_CNT) state_d = S_SAMPLE;
         default:        state_d = (x_q == 4'hF) ? S_DONE : S_FIRST;
      endcase
   end
   // pass uses next-state err/signature so the final sample is included
   always_comb begin
      x_d    = launch ? 4'd0 : (sample && !last) ? x_q + 4'd1 : x_q;
      cnt_d  = (launch || sample) ? 4'd0 : (state_q == S_SETTLE) ? cnt_q + 4'd1 : cnt_q;
      err_d  = launch ? 5'd0 : (sample && mis) ? err_q + 5'd1 : err_q;
      busy_d = launch ? 1'b1 : last ? 1'b0 : busy_q;
      done_d = launch ? 1'b0 : last ? 1'b1 : done_q;
      pass_d = launch ? 1'b0 : last ? (err_d == 5'd0 && sig_ok) : pass_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         cnt_q  <= '0;
         err_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         x_q    <= x_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pass_q <= pass_d;
      end
   end
   assign x       = x_q;
   assign err_cnt = err_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
endmodule

// File: tb/tb_logic_response_checker.sv
// tb_logic_response_checker: table-driven logic-block model feeding two checkers (SETTLE=1 and SETTLE=0).
// Expected counts and signatures come from a whole-table reference model; honours LRC_SIG_CHECK_EN.
module tb_logic_response_checker;
   function automatic logic [2:0] f(input logic [3:0] v);
      return {v[3] ^ v[2], (v[1] & v[0]) | v[3], v[0]};
   endfunction
   function automatic logic [15:0] golden_sig();
      logic [15:0] s = 16'hFFFF;
      for (int v = 0; v < 16; v++)
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {13'b0, f(4'(v))};
      return s;
   endfunction
   localparam logic [15:0] EXP = golden_sig();

   logic clk = 0, rst = 1;
   logic [1:0] start = '0;
   logic [3:0] xo[2];
   logic [2:0] y[2], yinv[2];
   logic busy[2], done[2], pass[2];
   logic [4:0] err[2];
   logic [15:0] sig[2];
   logic [2:0] ytab[16], yitab[16];
   int ntot = 0, npass = 0, nfail = 0;
   always #5 clk = ~clk;
   assign y[0] = ytab[xo[0]];
   assign yinv[0] = yitab[xo[0]];
   assign y[1] = ytab[xo[1]];
   assign yinv[1] = yitab[xo[1]];

   logic_response_checker #(.NUM_OUT(3), .SETTLE(1), .SEED(16'hFFFF), .EXP_SIG(EXP)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .x(xo[0]), .y(y[0]), .yinv(yinv[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err[0]), .signature(sig[0]));
   logic_response_checker #(.NUM_OUT(3), .SETTLE(0), .SEED(16'hFFFF), .EXP_SIG(EXP)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .x(xo[1]), .y(y[1]), .yinv(yinv[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err[1]), .signature(sig[1]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // reference model: whole-table view of what one sweep should report
   function automatic int exp_err();
      int n = 0;
      for (int v = 0; v < 16; v++)
         for (int b = 0; b < 3; b++)
            if (ytab[v][b] == yitab[v][b]) begin
               n++;
               break;
            end
      return n;
   endfunction
   function automatic logic [15:0] exp_sig();
`ifdef LRC_SIG_CHECK_EN
      int s = 16'hFFFF;
      for (int v = 0; v < 16; v++)
         s = (((s * 2) & 16'hFFFF) | (((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1)) ^ int'(ytab[v]);
      return 16'(s);
`else
      return 16'h0000;
`endif
   endfunction
   function automatic logic exp_pass();
`ifdef LRC_SIG_CHECK_EN
      return exp_err() == 0 && exp_sig() == EXP;
`else
      return exp_err() == 0;
`endif
   endfunction
   task automatic load_golden();
      for (int v = 0; v < 16; v++) begin
         ytab[v] = f(4'(v));
         yitab[v] = ~f(4'(v));
      end
   endtask
   task automatic run(input int k, input bit extra, output int bcyc, output int xbad);
      int per = (k == 0) ? 2 : 1;
      start[k] = 1'b1;
      tick();
      start[k] = 1'b0;
      chk("done_clr", done[k], 0);
      chk("busy_rise", busy[k], 1);
      bcyc = 0;
      xbad = 0;
      while (busy[k] && bcyc < 100) begin
         if (xo[k] != 4'(bcyc / per)) xbad++;
         start[k] = extra && (xo[k] == 4'd3 || xo[k] == 4'd10);
         bcyc++;
         tick();
      end
      start[k] = 1'b0;
      chk("done", done[k], 1);
   endtask
   task automatic results(input int k, input string tag);
      chk({tag, "_err"}, err[k], exp_err());
      chk({tag, "_sig"}, sig[k], exp_sig());
      chk({tag, "_pass"}, pass[k], exp_pass());
   endtask

   initial begin
      int b, xb, n;
      logic [4:0] e1;
      logic [15:0] s1;
      logic p1;
      load_golden();
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_x", xo[k], 0);
         chk("rst_busy", busy[k], 0);
         chk("rst_done", done[k], 0);
         chk("rst_pass", pass[k], 0);
         chk("rst_err", err[k], 0);
`ifdef LRC_SIG_CHECK_EN
         chk("rst_sig", sig[k], 16'hFFFF);
`else
         chk("rst_sig", sig[k], 0);
`endif
      end
      rst = 0;
      tick();
      // golden sweep
      run(0, 0, b, xb);
      chk("t1_busy", b, 32);
      chk("t1_xstep", xb, 0);
      chk("t1_pass_golden", pass[0], 1);
      results(0, "t1");
      // random tables with occasional complement faults
      repeat (4) begin
         for (int v = 0; v < 16; v++) begin
            ytab[v] = 3'($urandom);
            yitab[v] = ~ytab[v] ^ (($urandom_range(0, 2) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b0);
         end
         run(0, 0, b, xb);
         chk("rnd_busy", b, 32);
         results(0, "rnd");
      end
      // yinv[0] stuck at 0 with y0 = x[0]
      load_golden();
      for (int v = 0; v < 16; v++) yitab[v][0] = 1'b0;
      run(0, 0, b, xb);
      chk("t2_err", err[0], 8);
      chk("t2_pass", pass[0], 0);
      results(0, "t2");
      // reset mid-run at x==7
      load_golden();
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      n = 0;
      while (xo[0] != 4'd7 && n < 100) begin
         n++;
         tick();
      end
      chk("t3_reach7", xo[0], 7);
      rst = 1;
      tick();
      rst = 0;
      chk("t3_x", xo[0], 0);
      chk("t3_busy", busy[0], 0);
      chk("t3_done", done[0], 0);
      chk("t3_err", err[0], 0);
`ifdef LRC_SIG_CHECK_EN
      chk("t3_sig", sig[0], 16'hFFFF);
`else
      chk("t3_sig", sig[0], 0);
`endif
      run(0, 0, b, xb);
      chk("t3_busy_rerun", b, 32);
      results(0, "t3");
      // start pulses while busy
      run(0, 1, b, xb);
      chk("t4_busy", b, 32);
      chk("t4_xstep", xb, 0);
      results(0, "t4");
      // SETTLE=0, back-to-back
      run(1, 0, b, xb);
      chk("t5_busy_a", b, 16);
      chk("t5_xstep", xb, 0);
      results(1, "t5a");
      e1 = err[1];
      s1 = sig[1];
      p1 = pass[1];
      run(1, 0, b, xb);
      chk("t5_busy_b", b, 16);
      chk("t5_err_same", err[1], e1);
      chk("t5_sig_same", sig[1], s1);
      chk("t5_pass_same", pass[1], p1);
      // single y[2] flip at x==12, complements consistent
      load_golden();
      ytab[12][2] = ~ytab[12][2];
      yitab[12] = ~ytab[12];
      run(0, 0, b, xb);
      chk("t6_err", err[0], 0);
`ifdef LRC_SIG_CHECK_EN
      chk("t6_sig_differs", sig[0] != EXP, 1);
      chk("t6_pass", pass[0], 0);
`else
      chk("t6_pass", pass[0], 1);
`endif
      results(0, "t6");
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
